// File: rtl/rnd_arbiter.sv
// ---------------------------------------------------------------------------
// rnd_arbiter
//
// Purpose:
//   Shares one 32-bit Galois LFSR (x^32 + x^22 + x^2 + x + 1) among N_REQ
//   masked-gadget requesters. After reset the LFSR is stepped WARM times with
//   nothing delivered. After that, requesters are served round-robin. Each
//   grant hands out the low W bits of the current LFSR state, and then the
//   LFSR steps. A word is therefore never given to two gadgets.
//
// Parameters:
//   N_REQ : number of requesters (2..16)
//   W     : width of each delivered word (1..32), low bits of the LFSR state
//   WARM  : LFSR steps discarded after reset or reseed (1..65535)
//
// Ports:
//   C          in   1      clock, rising edge
//   RN         in   1      asynchronous active-low reset
//   req        in   N_REQ  level request, bit i = requester i wants a word
//   ack        out  N_REQ  registered one-hot grant, one pulse per word
//   rnd        out  W      registered word, forced to 0 while ack == 0
//   ready      out  1      high once warm-up is complete
//   seed_valid in   1      (RND_SEED_EN only) load seed and restart warm-up
//   seed       in   32     (RND_SEED_EN only) new LFSR seed, 0 maps to 1
//
// Optional feature:
//   Define RND_SEED_EN to add the seed_valid/seed reseed ports. Without it,
//   the LFSR is seeded only by reset, with 32'h00000001.
// ---------------------------------------------------------------------------
module rnd_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int WARM  = 64
) (
    input  logic             C,
    input  logic             RN,
    input  logic [N_REQ-1:0] req,
`ifdef RND_SEED_EN
    input  logic             seed_valid,
    input  logic [31:0]      seed,
`endif
    output logic [N_REQ-1:0] ack,
    output logic [W-1:0]     rnd,
    output logic             ready
);

    // Width of the round-robin pointer and of winner indices.
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [31:0]   LFSR_SEED  = 32'h0000_0001;
    localparam logic [31:0]   LFSR_TAPS  = 32'h8020_0003;
    localparam logic [15:0]   WARM_LAST  = 16'(WARM - 1);
    localparam logic [PW-1:0] PTR_LAST   = PW'(N_REQ - 1);
    localparam logic [PW:0]   N_REQ_EXT  = (PW + 1)'(N_REQ);

    typedef enum logic {
        WARMUP = 1'b0,
        SERVE  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [31:0]      lfsr_q,  lfsr_d;
    logic [15:0]      cnt_q,   cnt_d;
    logic [PW-1:0]    ptr_q,   ptr_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic [W-1:0]     rnd_q,   rnd_d;
    logic             ready_q, ready_d;

    // -----------------------------------------------------------------------
    // LFSR next state
    // -----------------------------------------------------------------------
    // This is a right-shifting Galois form. The bit shifted out of position 0
    // is folded back into the tap positions. State 0 maps to itself, so it
    // must never be loaded. Reset uses a nonzero seed, and a zero reseed is
    // replaced by LFSR_SEED.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] nxt;
        nxt = s >> 1;
        if (s[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        return nxt;
    endfunction

    logic [31:0] lfsr_adv;
    assign lfsr_adv = lfsr_step(lfsr_q);

    // -----------------------------------------------------------------------
    // Round-robin candidate rotation
    // -----------------------------------------------------------------------
    // Candidate slot gi is the requester at (ptr + gi) mod N_REQ. The sum is
    // at most 2*N_REQ-2, which fits in PW+1 bits. One conditional subtract is
    // therefore enough for the modulo, even when N_REQ is not a power of two.
    logic [PW-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_req;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        logic [PW:0] sum;
        assign sum          = {1'b0, ptr_q} + (PW + 1)'(gi);
        assign cand_idx[gi] = (sum >= N_REQ_EXT) ? PW'(sum - N_REQ_EXT)
                                                 : PW'(sum);
        assign cand_req[gi] = req[cand_idx[gi]];
    end

    // The loop runs from the highest offset down, so the lowest offset that
    // is requesting overwrites the others. That requester sits closest to
    // ptr in scan order and is the round-robin winner.
    logic          win_found;
    logic [PW-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_idx = cand_idx[k];
            end
        end
    end

    assign win_found = |cand_req;

    // One-hot grant vector for the winner.
    logic [N_REQ-1:0] win_onehot;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
        assign win_onehot[gi] = (win_idx == PW'(gi));
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // Defaults: hold the datapath and issue no grant. rnd stays 0 unless
        // a word is actually handed out, so a stale word never stays visible.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        rnd_d   = '0;
        ready_d = ready_q;

        case (state_q)
            WARMUP: begin
                // Requests are ignored here. The LFSR just runs WARM steps.
                // ready rises at the same edge that leaves WARMUP, so it is
                // high exactly WARM cycles after warm-up starts.
                lfsr_d  = lfsr_adv;
                ready_d = 1'b0;
                if (cnt_q == WARM_LAST) begin
                    state_d = SERVE;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end

            SERVE: begin
                ready_d = 1'b1;
                if (win_found) begin
                    // The current state is the word handed out. The LFSR then
                    // steps, so the next grant gets a new word. With no grant
                    // the LFSR is held, and no word is skipped.
                    ack_d  = win_onehot;
                    rnd_d  = lfsr_q[W-1:0];
                    lfsr_d = lfsr_adv;
                    ptr_d  = (win_idx == PTR_LAST) ? '0 : win_idx + PW'(1);
                end
            end

            default: begin
                state_d = WARMUP;
                ready_d = 1'b0;
            end
        endcase

`ifdef RND_SEED_EN
        // A reseed overrides everything evaluated above. Any grant in the
        // same cycle is dropped, and ptr keeps its value.
        if (seed_valid) begin
            state_d = WARMUP;
            lfsr_d  = (seed == 32'h0) ? LFSR_SEED : seed;
            cnt_d   = '0;
            ptr_d   = ptr_q;
            ack_d   = '0;
            rnd_d   = '0;
            ready_d = 1'b0;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state_q <= WARMUP;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            ack_q   <= '0;
            rnd_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            rnd_q   <= rnd_d;
            ready_q <= ready_d;
        end
    end

    assign ack   = ack_q;
    assign rnd   = rnd_q;
    assign ready = ready_q;

endmodule

// File: doc/rnd_arbiter.md
Name: rnd_arbiter

Overview:
- Sequential controller that shares one internal 32-bit randomness source (Galois LFSR) among N_REQ masked-gadget requesters.
- It runs a warm-up phase after reset, then grants requesters one fresh W-bit word per grant, round-robin.
- Each word is issued exactly once, so two gadgets never receive the same randomness.
- Sits between the PRNG domain and the masked gadget instances built from the BUF/NOT/AND/XOR/DFF cell set.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- W, 32, width of the randomness word delivered per grant (1..32); the word is the low W bits of the LFSR state.
- WARM, 64, number of LFSR steps discarded after reset or reseed (1..65535).

Ports:
- C  input  1  clock, rising edge.
- RN  input  1  asynchronous active-low reset.
- req  input  N_REQ  level request per requester; bit i high = requester i wants one word.
- ack  output  N_REQ  registered one-hot grant; pulses one cycle per delivered word.
- rnd  output  W  registered randomness word, valid only while ack is nonzero.
- ready  output  1  high once warm-up is complete (state SERVE).

Behaviour:
- Reset (RN=0, asynchronous): ack=0, rnd=0, ready=0, lfsr=32'h00000001, ptr=0, cnt=0, state=WARMUP.
- LFSR step: if lfsr[0]=1, next=(lfsr>>1)^32'h80200003; else next=lfsr>>1. Polynomial is x^32+x^22+x^2+x+1.
- WARMUP state:
  - LFSR steps every cycle and cnt increments; ack=0, rnd=0, ready=0; req is ignored.
  - At the edge where cnt reaches WARM-1, state becomes SERVE and ready is registered to 1 at that same edge.
  - So ready is high exactly WARM cycles after RN deassertion.
- SERVE state, evaluated at each rising edge:
  - Winner = first i with req[i]=1, scanning ptr, ptr+1, …, wrapping modulo N_REQ.
  - If a winner exists: ack <= onehot(winner), rnd <= lfsr[W-1:0], lfsr <= step(lfsr), ptr <= (winner+1) mod N_REQ.
  - If no req: ack <= 0, rnd <= 0; lfsr and ptr are held.
  - LFSR advances only on a grant.
- Latency: one cycle from a sampled req to ack/rnd.
- At most one grant per cycle. A requester holding req high is served again when its turn comes. The requester must drop req in the cycle ack is seen to avoid an extra word.
- rnd is forced to 0 whenever ack=0, so a stale word never remains visible.
- Pointer wrap: a winner at index N_REQ-1 sets ptr=0.
- Reset mid-operation: everything returns to reset values immediately and any in-flight ack is lost. After RN release, warm-up restarts from seed 32'h00000001.
- LFSR lock-up: state 0 is unreachable from reset. An all-zero seed (optional feature) is replaced by 32'h00000001.

Optional Feature:
- Macro: RND_SEED_EN.
- With RND_SEED_EN defined:
  - Adds ports seed_valid (input, 1) and seed (input, 32).
  - When seed_valid=1 at an edge: lfsr <= (seed==0 ? 32'h00000001 : seed), cnt <= 0, state <= WARMUP, ready <= 0, ack <= 0, rnd <= 0.
  - Seed load has priority over a grant in the same cycle; that grant is not issued and ptr is unchanged.
- Without RND_SEED_EN: no seed ports exist; the LFSR is seeded only by reset, with 32'h00000001.

Test Plan:
- Warm-up (WARM=2, W=32): release RN, hold req=4'b0001 -> ready=0 for 2 cycles and ack=0 during warm-up. Once ready=1, the first grant gives ack=4'b0001, rnd=32'hC0300002. The next grant gives rnd=32'h60180001.
- Round-robin (N_REQ=4): req=4'b1111 held in SERVE -> successive acks 0001, 0010, 0100, 1000, 0001. Each rnd is a distinct consecutive LFSR state.
- Idle hold: req=0 for 5 cycles between grants -> ack=0, rnd=0 throughout. The next grant delivers the LFSR state following the previous grant, with no skipped words.
- Pointer skip/wrap: ptr=3 and req=4'b0101 -> ack=4'b0001 (wraps past index 3), then ptr=1 and the next ack=4'b0100.
- Async reset mid-grant: assert RN low between edges while ack=4'b0010 -> ack=0, rnd=0, ready=0 immediately. After release, the first word equals the warm-up-test word.
- (RND_SEED_EN) seed_valid=1 with seed=0 while req=4'b1111 -> no ack that cycle, ready drops, lfsr=32'h00000001, and warm-up repeats WARM cycles.
